post_glitch_sequencer: RTL
==========================

// Module: post_glitch_sequencer
// PURPOSE
//  Initiator side of the glitch path: watches the CPU POST bit and CPU reset, counts POST transitions
//  after boot, requests CPU slowdown, then raises 'glitch' to the glitcher for a fixed hold window.
//  Judges success (POST advances) or failure (timeout) and on failure pulses a CPU reset request
//  to retry. Sits between the board POST/reset pins and the glitcher's 'glitch' input.
// PARAMETERS
//  POST_SLOW_EDGE    10        POST edge count at which cpu_slow asserts
//  POST_GLITCH_EDGE  11        POST edge count at which glitch asserts (must be >= POST_SLOW_EDGE)
//  GLITCH_HOLD       20000     clk_96m cycles glitch stays high (> glitcher start+length / 2)
//  TIMEOUT           9600000   cycles in CHECK without a POST edge before failure (100 ms)
//  RESET_PULSE       96        cycles cpu_reset_req is held high on failure (1 us)
// PORTS
//  clk_96m        in   1   96 MHz system clock, all logic on rising edge
//  rst            in   1   synchronous, active-high reset
//  post_bit       in   1   asynchronous CPU POST bit; every toggle = one POST code change
//  cpu_reset_n    in   1   asynchronous CPU reset pin level (0 = CPU held in reset)
//  glitch         out  1   glitch request to glitcher; high only in GLITCH
//  cpu_slow       out  1   CPU clock slowdown request; high in SLOW, GLITCH, CHECK
//  cpu_reset_req  out  1   request to pull CPU reset low; high only in RESET
//  success        out  1   high in SUCCESS
//  attempts       out  8   failed attempt count, saturates at 255
// BEHAVIOUR
//  - Reset: all outputs 0, attempts 0, state IDLE, edge/timer counters 0.
//  - post_bit, cpu_reset_n each through 2-flop synchroniser; edge = XOR of sync stage and its delayed
//    copy (either polarity counts). Edge detect latency 3 cycles from pin to count.
//  - edge_cnt 5 bits, saturating at 31; cleared on entry to IDLE. timer 24 bits, cleared on each state entry.
//  - Global: synchronised cpu_reset_n == 0 in COUNT/SLOW/GLITCH/CHECK -> IDLE next cycle (no attempt
//    increment). In RESET and SUCCESS it is ignored, except SUCCESS -> IDLE on cpu_reset_n == 0.
//  - IDLE: wait for synchronised cpu_reset_n == 1 -> COUNT.
//  - COUNT: increment edge_cnt per edge; when edge_cnt reaches POST_SLOW_EDGE -> SLOW
//    (if POST_SLOW_EDGE == POST_GLITCH_EDGE go straight to GLITCH).
//  - SLOW: cpu_slow=1; edge_cnt reaches POST_GLITCH_EDGE -> GLITCH.
//  - GLITCH: glitch=1 for exactly GLITCH_HOLD cycles (timer 0..GLITCH_HOLD-1). A POST edge here sets
//    edge_seen flag; at hold end edge_seen -> SUCCESS, else -> CHECK. glitch deasserts same cycle.
//  - CHECK: first POST edge -> SUCCESS; timer == TIMEOUT-1 with no edge -> RESET; edge on the
//    timeout cycle wins (SUCCESS).
//  - RESET: cpu_reset_req=1 for RESET_PULSE cycles; attempts += 1 on entry (saturate); -> IDLE.
//  - SUCCESS: terminal; success=1, cpu_slow=0; leave only via rst or CPU reset reasserted.
//  - glitch and cpu_reset_req never high together; outputs are registered (decoded from next state).
//  - rst mid-operation overrides everything: outputs 0 next edge, attempts cleared.
// TESTING
//  - rst, cpu_reset_n=1, 11 post toggles 1 us apart -> cpu_slow rises after 10th, glitch after 11th
//    (3-cycle sync latency), glitch high exactly GLITCH_HOLD cycles.
//  - after glitch, toggle post 5 us later -> success=1, cpu_slow=0, attempts=0.
//  - no toggle after glitch (TIMEOUT=1000 override) -> cpu_reset_req high 96 cycles, attempts=1, IDLE.
//  - 256 forced failures -> attempts holds 255; CPU reset asserted while SLOW -> IDLE, attempts unchanged.
//  - post toggle during GLITCH hold -> glitch still full GLITCH_HOLD, then SUCCESS directly.
//  - edge on same cycle as timeout -> SUCCESS, no cpu_reset_req; rst during GLITCH -> glitch=0 next cycle.

Source files
------------

// File: rtl/post_glitch_sequencer.sv
// post_glitch_sequencer: watches CPU POST/reset, requests slowdown, fires a timed glitch, judges it, retries on failure
//  clk_96m        in   96 MHz clock, all logic on the rising edge
//  rst            in   synchronous active-high reset
//  post_bit       in   async CPU POST bit, each toggle is one POST code change
//  cpu_reset_n    in   async CPU reset pin level (0 = CPU held in reset)
//  glitch         out  glitch request, high only while holding the glitch window
//  cpu_slow       out  CPU clock slowdown request from slowdown through the success check
//  cpu_reset_req  out  pull CPU reset low, high only during the retry pulse
//  success        out  POST advanced after the glitch
//  attempts [7:0] out  failed attempt count, saturating at 255
module post_glitch_sequencer #(
  parameter int POST_SLOW_EDGE   = 10,
  parameter int POST_GLITCH_EDGE = 11,
  parameter int GLITCH_HOLD      = 20000,
  parameter int TIMEOUT          = 9600000,
  parameter int RESET_PULSE      = 96
) (
  input  logic       clk_96m,
  input  logic       rst,
  input  logic       post_bit,
  input  logic       cpu_reset_n,
  output logic       glitch,
  output logic       cpu_slow,
  output logic       cpu_reset_req,
  output logic       success,
  output logic [7:0] attempts
);
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_SLOW, S_GLITCH, S_CHECK, S_RESET, S_SUCCESS} state_t;
  localparam logic [4:0]  SLOW_N    = 5'(POST_SLOW_EDGE);
  localparam logic [4:0]  GLITCH_N  = 5'(POST_GLITCH_EDGE);
  localparam logic [23:0] HOLD_LAST = 24'(GLITCH_HOLD - 1);
  localparam logic [23:0] TO_LAST   = 24'(TIMEOUT - 1);
  localparam logic [23:0] RP_LAST   = 24'(RESET_PULSE - 1);
  state_t      state_q, state_d;
  logic [2:0]  post_sync_q, post_sync_d;
  logic [1:0]  rstn_sync_q, rstn_sync_d;
  logic [4:0]  edge_cnt_q, edge_cnt_d, cnt_inc;
  logic [23:0] timer_q, timer_d;
  logic        edge_seen_q, edge_seen_d;
  logic [7:0]  attempts_q, attempts_d;
  logic        glitch_q, glitch_d, cpu_slow_q, cpu_slow_d;
  logic        cpu_reset_req_q, cpu_reset_req_d, success_q, success_d;
  logic        post_edge, cpu_up, entering;
  assign post_edge     = post_sync_q[2] ^ post_sync_q[1];
  assign cpu_up        = rstn_sync_q[1];
  assign glitch        = glitch_q;
  assign cpu_slow      = cpu_slow_q;
  assign cpu_reset_req = cpu_reset_req_q;
  assign success       = success_q;
  assign attempts      = attempts_q;
  always_comb begin
    post_sync_d = {post_sync_q[1:0], post_bit};
    rstn_sync_d = {rstn_sync_q[0], cpu_reset_n};
    cnt_inc     = (post_edge && edge_cnt_q != 5'd31) ? edge_cnt_q + 5'd1 : edge_cnt_q;
    state_d     = state_q;
    case (state_q)
      S_IDLE:    state_d = cpu_up ? S_COUNT : S_IDLE;
      // equal thresholds skip SLOW entirely
      S_COUNT:   state_d = (cnt_inc >= GLITCH_N) ? S_GLITCH : (cnt_inc >= SLOW_N) ? S_SLOW : S_COUNT;
      S_SLOW:    state_d = (cnt_inc >= GLITCH_N) ? S_GLITCH : S_SLOW;
      // an edge on the final hold cycle still counts as seen
      S_GLITCH:  state_d = (timer_q != HOLD_LAST) ? S_GLITCH : (edge_seen_q || post_edge) ? S_SUCCESS : S_CHECK;
      S_CHECK:   state_d = post_edge ? S_SUCCESS : (timer_q == TO_LAST) ? S_RESET : S_CHECK;
      S_RESET:   state_d = (timer_q == RP_LAST) ? S_IDLE : S_RESET;
      S_SUCCESS: state_d = cpu_up ? S_SUCCESS : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (!cpu_up && state_q inside {S_COUNT, S_SLOW, S_GLITCH, S_CHECK}) state_d = S_IDLE;
    entering        = state_d != state_q;
    timer_d         = entering ? 24'd0 : timer_q + 24'd1;
    edge_cnt_d      = (entering && state_d == S_IDLE) ? 5'd0 :
                      (state_q inside {S_COUNT, S_SLOW}) ? cnt_inc : edge_cnt_q;
    edge_seen_d     = (state_q == S_GLITCH) && (edge_seen_q || post_edge);
    attempts_d      = (entering && state_d == S_RESET && attempts_q != 8'hFF) ? attempts_q + 8'd1 : attempts_q;
    glitch_d        = state_d == S_GLITCH;
    cpu_slow_d      = state_d inside {S_SLOW, S_GLITCH, S_CHECK};
    cpu_reset_req_d = state_d == S_RESET;
    success_d       = state_d == S_SUCCESS;
  end
  always_ff @(posedge clk_96m) begin
    if (rst) begin
      state_q         <= S_IDLE;
      post_sync_q     <= '0;
      rstn_sync_q     <= '0;
      edge_cnt_q      <= '0;
      timer_q         <= '0;
      edge_seen_q     <= 1'b0;
      attempts_q      <= '0;
      glitch_q        <= 1'b0;
      cpu_slow_q      <= 1'b0;
      cpu_reset_req_q <= 1'b0;
      success_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      post_sync_q     <= post_sync_d;
      rstn_sync_q     <= rstn_sync_d;
      edge_cnt_q      <= edge_cnt_d;
      timer_q         <= timer_d;
      edge_seen_q     <= edge_seen_d;
      attempts_q      <= attempts_d;
      glitch_q        <= glitch_d;
      cpu_slow_q      <= cpu_slow_d;
      cpu_reset_req_q <= cpu_reset_req_d;
      success_q       <= success_d;
    end
  end
endmodule
